// File: rtl/dsp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsp_pkg
// Purpose  : Shared sample types and constants for the codec/filter data path.
// Revision : 1.0  initial release
// ============================================================================
package dsp_pkg;

  // Offset-binary sample as delivered by the WM8731 ADC deserializer.
  typedef logic [15:0] sample_in_t;

  // Signed, left-aligned word consumed by the FIR filter.
  typedef logic signed [33:0] sample_fir_t;

  // Offset-binary code that represents a zero-amplitude sample.
  localparam sample_in_t ADC_ZERO = 16'h8000;

  // Left shift that aligns an ADC sample into the filter word.
  localparam int FIR_ALIGN = 16;

endpackage : dsp_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with a registered head word. A push is accepted
//            when not full or when a pop happens on the same edge; pops on
//            empty are ignored.
// Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
      $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] head;
  logic             pop_ok;
  logic             push_ok;
  logic             one_left;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign one_left = (count == CW'(1));
  assign pop_ok   = pop && !empty;
  // A full FIFO still takes a new word when the head leaves on the same edge.
  assign push_ok  = push && (!full || pop_ok);
  assign rd_next  = rd_ptr + AW'(1);
  assign rdata    = head;

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_next;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head register: refilled on a pop, or loaded directly when writing into empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
    end else if (pop_ok) begin
      if (one_left) begin
        // Last stored word leaves; a simultaneous push becomes the new head.
        if (push_ok) begin
          head <= wdata;
        end
      end else begin
        // At least two words held, so the next slot is already written.
        head <= mem[rd_next];
      end
    end else if (push_ok && empty) begin
      head <= wdata;
    end
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/to_signed.sv
`default_nettype none
// ============================================================================
// Module   : to_signed
// Purpose  : Converts offset-binary ADC samples into signed, left-aligned
//            filter words and buffers them so the FIR can stall the stream.
//            Samples arriving while the buffer is full and not draining are
//            dropped and flagged in a sticky overflow bit.
// Revision : 1.0  initial release
// ============================================================================
module to_signed
  import dsp_pkg::*;
#(
  parameter int IN_W  = $bits(sample_in_t),
  parameter int OUT_W = $bits(sample_fir_t),
  parameter int SHIFT = FIR_ALIGN,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IN_W-1:0]  i_data,
  input  logic             i_rdy,
  output logic [OUT_W-1:0] o_data,
  output logic             re,
  output logic             o_full,
  output logic             o_ovf,
  input  logic             ovf_clr
);

  generate
    if (IN_W + SHIFT > OUT_W) begin : g_width_check
      $error("to_signed: IN_W + SHIFT must not exceed OUT_W");
    end
  endgenerate

  logic [IN_W-1:0]         flipped;
  logic signed [OUT_W-1:0] extended;
  logic [OUT_W-1:0]        converted;
  logic                    full;
  logic                    empty;
  logic                    pop;
  logic                    ovf_set;

  // Inverting the MSB turns offset binary into two's complement; the signed
  // cast then sign-extends before the word is left-aligned with zero LSBs.
  assign flipped   = {~i_data[IN_W-1], i_data[IN_W-2:0]};
  assign extended  = OUT_W'($signed(flipped));
  assign converted = extended << SHIFT;

  assign re      = !empty;
  assign o_full  = full;
  assign pop     = re && i_rdy;
  // A sample is lost only when full and the head is not leaving this cycle.
  assign ovf_set = we && full && !pop;

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (we),
    .pop   (pop),
    .wdata (converted),
    .rdata (o_data),
    .full  (full),
    .empty (empty)
  );

  // Sticky overflow flag; a fresh overflow outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ovf <= 1'b0;
    end else if (ovf_set) begin
      o_ovf <= 1'b1;
    end else if (ovf_clr) begin
      o_ovf <= 1'b0;
    end
  end

endmodule : to_signed
`default_nettype wire
